// File: rtl/v810_icache_pkg.sv
// Shared types for the V810 instruction-cache controller: FSM states and the
// tag-RAM entry layout.
package v810_icache_pkg;

  localparam int IDX_W = 7;
  localparam int TAG_W = 30 - 1 - IDX_W;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    HIT,
    BYPASS,
    FILL_A,
    FILL_B,
    ACK
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/v810_icache_ctl.sv
// Direct-mapped instruction-cache controller: hit/miss lookup, critical-word-first
// two-beat line fill, uncached bypass, and whole-cache invalidation.
module v810_icache_ctl #(
  parameter int IDX_W = v810_icache_pkg::IDX_W,
  parameter int TAG_W = v810_icache_pkg::TAG_W
) (
  input  logic               CLK,
  input  logic               RESn,
  input  logic               ice,
  input  logic               inv_req,
  output logic               inv_done,
  input  logic               req,
  input  logic [29:0]        addr,
  output logic               ack,
  output logic [31:0]        rdata,
  output logic               mem_req,
  output logic [29:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic [IDX_W-1:0]   tag_rd_addr,
  input  logic [TAG_W:0]     tag_rd_data,
  output logic               tag_wr_en,
  output logic [IDX_W-1:0]   tag_wr_addr,
  output logic [TAG_W:0]     tag_wr_data,
  output logic [IDX_W:0]     dat_rd_addr,
  input  logic [31:0]        dat_rd_data,
  output logic               dat_wr_en,
  output logic [IDX_W:0]     dat_wr_addr,
  output logic [31:0]        dat_wr_data
);
  import v810_icache_pkg::*;

  state_t             state;
  logic [IDX_W-1:0]   clr_cnt;
  logic               word;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;

  assign word = addr[0];
  assign idx  = addr[IDX_W:1];
  assign tag  = addr[29:IDX_W+1];
  assign hit  = tag_rd_data[TAG_W] && (tag_rd_data[TAG_W-1:0] == tag);

  assign tag_rd_addr = idx;
  assign dat_rd_addr = {idx, word};

  // Second fill beat fetches the other half of the line.
  assign mem_addr = (state == FILL_B) ? {addr[29:1], ~word} : addr;

  assign dat_wr_en   = mem_ack && ((state == FILL_A) || (state == FILL_B));
  assign dat_wr_addr = {idx, (state == FILL_B) ? ~word : word};
  assign dat_wr_data = mem_rdata;

  // The tag is only written on the final beat, so a half-filled line never looks valid.
  // RESn gates the clear write so no write is issued while reset is held.
  assign tag_wr_en   = ((state == CLEAR) && RESn) || ((state == FILL_B) && mem_ack);
  assign tag_wr_addr = (state == CLEAR) ? clr_cnt : idx;
  assign tag_wr_data = (state == CLEAR) ? '0 : {1'b1, tag};

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ack      <= 1'b0;
      inv_done <= 1'b0;
      mem_req  <= 1'b0;
      rdata    <= '0;
    end else begin
      ack      <= 1'b0;
      inv_done <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == '1) begin
            state    <= IDLE;
            inv_done <= inv_req;
          end
        end
        IDLE: begin
          // inv_req is still high in the inv_done cycle; do not restart the clear.
          if (inv_req && !inv_done) begin
            state <= CLEAR;
          end else if (req) begin
            if (ice && hit) begin
              state <= HIT;
              ack   <= 1'b1;
              rdata <= dat_rd_data;
            end else begin
              state   <= ice ? FILL_A : BYPASS;
              mem_req <= 1'b1;
            end
          end
        end
        HIT: state <= IDLE;
        BYPASS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
            ack     <= 1'b1;
            state   <= ACK;
          end
        end
        FILL_A: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
            state   <= FILL_B;
          end
        end
        FILL_B: begin
          // mem_req enters FILL_B low, giving the bus one idle cycle between beats.
          if (mem_ack) begin
            mem_req <= 1'b0;
            ack     <= 1'b1;
            state   <= ACK;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

  a_addr_stable: assert property (@(posedge CLK) disable iff (!RESn)
    (req && !ack) |=> $stable(addr));

endmodule

// File: tb/tb_v810_icache_ctl.sv
// Scoreboard bench for v810_icache_ctl with behavioural tag/data RAMs and a
// variable-latency memory responder.
module tb_v810_icache_ctl;
  import v810_icache_pkg::*;

  localparam int IW = 7;
  localparam int TW = 22;

  logic          CLK = 1'b0;
  logic          RESn;
  logic          ice, inv_req, inv_done, req, ack;
  logic [29:0]   addr;
  logic [31:0]   rdata;
  logic          mem_req, mem_ack;
  logic [29:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic [IW-1:0] tag_rd_addr, tag_wr_addr;
  logic [TW:0]   tag_rd_data, tag_wr_data;
  logic          tag_wr_en, dat_wr_en;
  logic [IW:0]   dat_rd_addr, dat_wr_addr;
  logic [31:0]   dat_rd_data, dat_wr_data;

  v810_icache_ctl #(.IDX_W(IW), .TAG_W(TW)) dut (
    .CLK(CLK), .RESn(RESn), .ice(ice), .inv_req(inv_req), .inv_done(inv_done),
    .req(req), .addr(addr), .ack(ack), .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data), .tag_wr_en(tag_wr_en),
    .tag_wr_addr(tag_wr_addr), .tag_wr_data(tag_wr_data),
    .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data), .dat_wr_en(dat_wr_en),
    .dat_wr_addr(dat_wr_addr), .dat_wr_data(dat_wr_data)
  );

  always #5 CLK = ~CLK;

  logic [TW:0]  tag_ram [128];
  logic [31:0]  dat_ram [256];
  bit           scramble;

  assign tag_rd_data = tag_ram[tag_rd_addr];
  assign dat_rd_data = dat_ram[dat_rd_addr];

  // Power-up junk: every entry looks valid with tag 0 until the clear sweeps it.
  always @(posedge CLK) begin
    if (scramble) begin
      for (int i = 0; i < 128; i++) tag_ram[i] <= {1'b1, {TW{1'b0}}};
    end else if (tag_wr_en) begin
      tag_ram[tag_wr_addr] <= tag_wr_data;
    end
    if (dat_wr_en) dat_ram[dat_wr_addr] <= dat_wr_data;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  logic [31:0] exp_q[$];
  logic [29:0] mem_exp_q[$];
  bit          ref_valid [128];
  logic [TW-1:0] ref_tag [128];

  int            n_mem_ack = 0, n_dat_wr = 0, n_tag_vwr = 0, n_tag_clr = 0;
  logic [IW-1:0] last_tag_addr;
  logic [TW:0]   last_tag_data;

  initial begin
    forever begin
      @(negedge CLK);
      if (ack) begin
        if (exp_q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
        else check("rdata", rdata, exp_q.pop_front());
      end
      if (mem_ack) n_mem_ack++;
      if (dat_wr_en) n_dat_wr++;
      if (tag_wr_en) begin
        if (tag_wr_data[TW]) begin
          n_tag_vwr++;
          last_tag_addr = tag_wr_addr;
          last_tag_data = tag_wr_data;
        end else begin
          n_tag_clr++;
        end
      end
    end
  end

  int mwait = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESn) begin
        mem_ack = 1'b0;
        mwait   = $urandom_range(0, 2);
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (mwait > 0) begin
          mwait--;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          if (mem_exp_q.size() == 0) check("mem_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
          else check("mem_addr", 32'(mem_addr), 32'(mem_exp_q.pop_front()));
          mwait = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic reset_and_clear();
    int good;
    int nv;
    RESn    = 1'b0;
    req     = 1'b0;
    inv_req = 1'b0;
    mem_exp_q.delete();
    for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_inv_done", 32'(inv_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_tag_wr_en", 32'(tag_wr_en), 32'd0);
    check("rst_dat_wr_en", 32'(dat_wr_en), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge CLK);
    #1 RESn = 1'b1;
    good = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      if (tag_wr_en && (tag_wr_addr == IW'(i)) && (tag_wr_data == '0)) good++;
    end
    check("clear_writes", good, 128);
    @(negedge CLK);
    check("clear_done_no_write", 32'(tag_wr_en), 32'd0);
    check("clear_no_inv_done", 32'(inv_done), 32'd0);
    nv = 0;
    for (int i = 0; i < 128; i++) if (tag_ram[i][TW] !== 1'b0) nv++;
    check("clear_entries_valid", nv, 0);
  endtask

  task automatic fetch(input logic [29:0] a, input logic ice_v, input logic with_inv);
    logic [IW-1:0] ix;
    logic [TW-1:0] tg;
    bit exp_hit, exp_fill, got, inv_seen;
    int m0, d0, t0, c0, cyc;
    ix = a[IW:1];
    tg = a[29:IW+1];
    if (with_inv) for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    exp_hit  = ice_v && ref_valid[ix] && (ref_tag[ix] == tg);
    exp_fill = ice_v && !exp_hit;
    exp_q.push_back(mem_fn(a));
    if (!exp_hit) begin
      mem_exp_q.push_back(a);
      if (ice_v) mem_exp_q.push_back({a[29:1], ~a[0]});
    end
    m0 = n_mem_ack; d0 = n_dat_wr; t0 = n_tag_vwr; c0 = n_tag_clr;
    addr = a; ice = ice_v; req = 1'b1; inv_req = with_inv;
    cyc = 0; got = 0; inv_seen = 0;
    while (!got && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (inv_done) begin
        inv_seen = 1;
        inv_req  = 1'b0;
      end
      if (ack) got = 1;
    end
    req = 1'b0;
    check("ack_timeout", 32'(got), 32'd1);
    if (exp_hit) check("hit_latency", cyc, 1);
    check("mem_txns", n_mem_ack - m0, exp_hit ? 0 : (ice_v ? 2 : 1));
    check("dat_writes", n_dat_wr - d0, exp_fill ? 2 : 0);
    check("tag_writes", n_tag_vwr - t0, exp_fill ? 1 : 0);
    if (exp_fill) begin
      check("tag_wr_addr", 32'(last_tag_addr), 32'(ix));
      check("tag_wr_data", 32'(last_tag_data), 32'({1'b1, tg}));
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = tg;
    end
    if (with_inv) begin
      check("inv_done_seen", 32'(inv_seen), 32'd1);
      check("inv_clear_writes", n_tag_clr - c0, 128);
    end
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    logic        ice_r;
    int          w, t0;
    RESn = 1'b0; req = 1'b0; inv_req = 1'b0; ice = 1'b1; addr = '0;
    scramble = 1'b1;
    repeat (2) @(negedge CLK);
    scramble = 1'b0;
    reset_and_clear();

    fetch(30'h0000_0101, 1'b1, 1'b0);
    fetch(30'h0000_0100, 1'b1, 1'b0);
    fetch(30'h0000_0101, 1'b1, 1'b0);
    fetch(30'h0002_0101, 1'b1, 1'b0);
    fetch(30'h0000_0101, 1'b1, 1'b0);
    fetch(30'h0000_0101, 1'b0, 1'b0);
    fetch(30'h0000_07F3, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      a = '0;
      a[IW+2:IW+1] = 2'($urandom_range(0, 3));
      a[2:0]       = 3'($urandom_range(0, 7));
      ice_r = ($urandom_range(0, 3) != 0);
      fetch(a, ice_r, 1'b0);
    end

    fetch(30'h0000_0555, 1'b1, 1'b1);

    // Reset pulsed while the second fill beat is pending.
    t0 = n_tag_vwr;
    mem_exp_q.push_back(30'h0000_0301);
    mem_exp_q.push_back(30'h0000_0300);
    addr = 30'h0000_0301; ice = 1'b1; req = 1'b1;
    w = 0;
    while (!mem_ack && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check("fill_a_ack_seen", 32'(mem_ack), 32'd1);
    @(negedge CLK);
    RESn = 1'b0;
    req  = 1'b0;
    reset_and_clear();
    check("rst_fill_no_tag_write", n_tag_vwr - t0, 0);
    fetch(30'h0000_0301, 1'b1, 1'b0);
    fetch(30'h0000_0300, 1'b1, 1'b0);

    repeat (4) @(negedge CLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", mem_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
